// File: rtl/axi_lite_master_ctrl_pkg.sv
// Shared definitions for the AXI4-Lite master controller: FSM states and response codes.
package axi_lite_master_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WB,
    ST_RA,
    ST_RD,
    ST_RSP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_master_ctrl.sv
// Single-outstanding AXI4-Lite master: turns a valid/ready command stream into AXI4-Lite
// transactions and returns one registered response per command, counting error responses.
module axi_lite_master_ctrl
  import axi_lite_master_ctrl_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32,
  parameter int unsigned ERR_W = 16
) (
  input  logic            ACLK,
  input  logic            ARESETN,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW-1:0]   cmd_wdata,
  input  logic [DW/8-1:0] cmd_wstrb,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_write,
  output logic [DW-1:0]   rsp_rdata,
  output logic [1:0]      rsp_resp,
  output logic [ERR_W-1:0] err_count,
  output logic [AW-1:0]   M_AXIL_AWADDR,
  output logic            M_AXIL_AWVALID,
  input  logic            M_AXIL_AWREADY,
  output logic [DW-1:0]   M_AXIL_WDATA,
  output logic [DW/8-1:0] M_AXIL_WSTRB,
  output logic            M_AXIL_WVALID,
  input  logic            M_AXIL_WREADY,
  input  logic [1:0]      M_AXIL_BRESP,
  input  logic            M_AXIL_BVALID,
  output logic            M_AXIL_BREADY,
  output logic [AW-1:0]   M_AXIL_ARADDR,
  output logic            M_AXIL_ARVALID,
  input  logic            M_AXIL_ARREADY,
  input  logic [DW-1:0]   M_AXIL_RDATA,
  input  logic [1:0]      M_AXIL_RRESP,
  input  logic            M_AXIL_RVALID,
  output logic            M_AXIL_RREADY
);

  state_t r_state, w_state_nxt;
  logic   r_aw_done, r_w_done;
  logic   w_cmd_hs, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_rsp_hs;
  logic   w_fin;
  logic [1:0] w_fin_resp;

  assign w_cmd_hs  = cmd_valid && cmd_ready;
  assign w_aw_hs   = M_AXIL_AWVALID && M_AXIL_AWREADY;
  assign w_w_hs    = M_AXIL_WVALID && M_AXIL_WREADY;
  assign w_b_hs    = M_AXIL_BVALID && M_AXIL_BREADY;
  assign w_ar_hs   = M_AXIL_ARVALID && M_AXIL_ARREADY;
  assign w_r_hs    = M_AXIL_RVALID && M_AXIL_RREADY;
  assign w_rsp_hs  = rsp_valid && rsp_ready;

  // Write and read completion share one response-loading path.
  assign w_fin      = ((r_state == ST_WB) && w_b_hs) || ((r_state == ST_RD) && w_r_hs);
  assign w_fin_resp = (r_state == ST_WB) ? M_AXIL_BRESP : M_AXIL_RRESP;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_cmd_hs) w_state_nxt = cmd_write ? ST_WR : ST_RA;
      ST_WR:   if (r_aw_done && r_w_done) w_state_nxt = ST_WB;
      ST_WB:   if (w_b_hs) w_state_nxt = ST_RSP;
      ST_RA:   if (w_ar_hs) w_state_nxt = ST_RD;
      ST_RD:   if (w_r_hs) w_state_nxt = ST_RSP;
      ST_RSP:  if (w_rsp_hs) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cmd_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_write      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_resp       <= RESP_OKAY;
      err_count      <= '0;
      M_AXIL_AWADDR  <= '0;
      M_AXIL_AWVALID <= 1'b0;
      M_AXIL_WDATA   <= '0;
      M_AXIL_WSTRB   <= '0;
      M_AXIL_WVALID  <= 1'b0;
      M_AXIL_BREADY  <= 1'b0;
      M_AXIL_ARADDR  <= '0;
      M_AXIL_ARVALID <= 1'b0;
      M_AXIL_RREADY  <= 1'b0;
      r_aw_done      <= 1'b0;
      r_w_done       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_hs) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              M_AXIL_AWADDR  <= cmd_addr;
              M_AXIL_WDATA   <= cmd_wdata;
              M_AXIL_WSTRB   <= cmd_wstrb;
              M_AXIL_AWVALID <= 1'b1;
              M_AXIL_WVALID  <= 1'b1;
              r_aw_done      <= 1'b0;
              r_w_done       <= 1'b0;
            end else begin
              M_AXIL_ARADDR  <= cmd_addr;
              M_AXIL_ARVALID <= 1'b1;
            end
          end
        end
        ST_WR: begin
          if (w_aw_hs) begin
            M_AXIL_AWVALID <= 1'b0;
            r_aw_done      <= 1'b1;
          end
          if (w_w_hs) begin
            M_AXIL_WVALID <= 1'b0;
            r_w_done      <= 1'b1;
          end
          if (r_aw_done && r_w_done) M_AXIL_BREADY <= 1'b1;
        end
        ST_WB: if (w_b_hs) M_AXIL_BREADY <= 1'b0;
        ST_RA: begin
          if (w_ar_hs) begin
            M_AXIL_ARVALID <= 1'b0;
            M_AXIL_RREADY  <= 1'b1;
          end
        end
        ST_RD: if (w_r_hs) M_AXIL_RREADY <= 1'b0;
        ST_RSP: begin
          if (w_rsp_hs) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: ;
      endcase

      if (w_fin) begin
        rsp_valid <= 1'b1;
        rsp_resp  <= w_fin_resp;
        rsp_write <= (r_state == ST_WB);
        rsp_rdata <= (r_state == ST_WB) ? '0 : M_AXIL_RDATA;
        if (is_err(w_fin_resp) && (err_count != '1)) err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule
